// File: rtl/rnd_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : rnd_byte_packer
//  Purpose  : Packs the 2-bit raw output of the randomizer core into bytes
//             and buffers them in a small show-ahead FIFO, presented to the
//             consumer through a valid/ready handshake. A completed byte that
//             finds the FIFO full (and not draining) is dropped and flags the
//             sticky overflow bit.
//  Config   : RND_PACKER_DEBIAS_EN - when defined, every accepted pair passes
//             through a von Neumann extractor (10 -> 1, 01 -> 0, 00/11
//             discarded) and a byte is formed from 8 yielded bits. When
//             undefined, 4 raw pairs form one byte.
//  Ports    : i_clk      - clock, rising edge
//             i_reset    - synchronous active-high reset
//             i_en       - sample qualifier for i_r
//             i_r[1:0]   - raw random pair
//             i_ready    - consumer ready
//             o_data[7:0]- FIFO head byte (8'h00 when empty)
//             o_valid    - FIFO non-empty
//             o_overflow - sticky byte-dropped flag
//             o_level    - FIFO occupancy, 0..FIFO_DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module rnd_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_en,
    input  logic [1:0]                    i_r,
    input  logic                          i_ready,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
`ifdef RND_PACKER_DEBIAS_EN
    // 8 yielded bits per byte; the 7 earlier bits are held in r_sh.
    localparam int c_CNT_W = 3;
    localparam int c_SH_W  = 7;
`else
    // 4 pairs per byte; the 3 earlier pairs are held in r_sh.
    localparam int c_CNT_W = 2;
    localparam int c_SH_W  = 6;
`endif

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_SH_W-1:0]  r_sh;
    logic               w_sample;
    logic [c_SH_W-1:0]  w_sh_next;
    logic [7:0]         w_byte;
    logic               w_push;

`ifdef RND_PACKER_DEBIAS_EN
    // Unequal pair yields its MSB as the bit: 10 -> 1, 01 -> 0.
    assign w_sample  = i_en && (i_r[1] ^ i_r[0]);
    assign w_sh_next = {r_sh[c_SH_W-2:0], i_r[1]};
    assign w_byte    = {r_sh, i_r[1]};
`else
    assign w_sample  = i_en;
    assign w_sh_next = {r_sh[c_SH_W-3:0], i_r};
    assign w_byte    = {r_sh, i_r};
`endif

    // Counter at its all-ones value means this sample completes the byte.
    assign w_push = w_sample && (r_cnt == {c_CNT_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (w_sample) begin
            // Counter wraps naturally whether or not the push is accepted.
            r_cnt <= r_cnt + c_CNT_W'(1);
            r_sh  <= w_sh_next;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;

    assign w_full    = (r_level == c_FULL_LVL);
    assign w_empty   = (r_level == '0);
    assign w_pop     = !w_empty && i_ready;
    // A push into a full FIFO still fits when the head leaves this cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push_ok) begin
                r_level <= r_level - c_LVL_W'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;
    assign o_level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_rnd_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rnd_byte_packer
//  Purpose  : Self-checking bench for rnd_byte_packer. A queue-based
//             reference model tracks the expected byte stream, occupancy and
//             overflow flag; directed scenarios plus randomized traffic are
//             compared cycle by cycle.
//  Config   : honours RND_PACKER_DEBIAS_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rnd_byte_packer;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_en = 1'b0;
    logic [1:0]       i_r = 2'b00;
    logic             i_ready = 1'b0;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             o_overflow;
    logic [LVL_W-1:0] o_level;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    int         m_cnt = 0;
    int         m_acc = 0;
    bit         m_ovf = 1'b0;

    rnd_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_r        (i_r),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_overflow (o_overflow),
        .o_level    (o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one rising edge, from the behavioural rules.
    task automatic model_edge(input bit rst, input bit en, input int r, input bit rdy);
        bit done;
        bit pop;
        int b;
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_acc = 0;
            m_ovf = 1'b0;
            return;
        end
        done = 1'b0;
        b    = 0;
        pop  = (m_q.size() != 0) && rdy;
`ifdef RND_PACKER_DEBIAS_EN
        if (en && (r == 2 || r == 1)) begin
            m_acc = m_acc * 2 + ((r == 2) ? 1 : 0);
            m_cnt++;
            if (m_cnt == 8) begin
                done = 1'b1;
                b = m_acc;
                m_acc = 0;
                m_cnt = 0;
            end
        end
`else
        if (en) begin
            m_acc = m_acc * 4 + r;
            m_cnt++;
            if (m_cnt == 4) begin
                done = 1'b1;
                b = m_acc;
                m_acc = 0;
                m_cnt = 0;
            end
        end
`endif
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back(8'(b));
            else m_ovf = 1'b1;
        end
    endtask

    // Apply inputs for one cycle, advance the model at the edge, then
    // compare all outputs 1 time unit after the edge.
    task automatic step(input bit rst, input bit en, input int r, input bit rdy);
        i_reset = rst;
        i_en    = en;
        i_r     = 2'(r);
        i_ready = rdy;
        @(posedge i_clk);
        model_edge(rst, en, r, rdy);
        #1;
        check("valid", 32'(o_valid), 32'(m_q.size() != 0));
        check("data", 32'(o_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("level", 32'(o_level), 32'(m_q.size()));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    initial begin
        // Reset state
        step(1, 1, 3, 1);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_level", 32'(o_level), 32'h0);
        check("rst_ovf", 32'(o_overflow), 32'h0);

`ifndef RND_PACKER_DEBIAS_EN
        // Basic packing and one-cycle latency
        step(0, 1, 3, 1);
        step(0, 1, 0, 1);
        step(0, 1, 2, 1);
        step(0, 1, 1, 1);
        check("c9_valid", 32'(o_valid), 32'h1);
        check("c9_data", 32'(o_data), 32'hC9);
        step(0, 0, 0, 1);
        check("c9_popped_valid", 32'(o_valid), 32'h0);
        check("c9_popped_level", 32'(o_level), 32'h0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) step(0, 1, 3, 0);
        check("fill_level", 32'(o_level), 32'h4);
        check("fill_ovf", 32'(o_overflow), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 0);
        check("ovf_set", 32'(o_overflow), 32'h1);
        check("ovf_level", 32'(o_level), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(o_data), 32'hFF);
            step(0, 0, 0, 1);
        end
        check("drained_level", 32'(o_level), 32'h0);
        check("ovf_sticky", 32'(o_overflow), 32'h1);

        // Push into full FIFO while it pops: no overflow
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 3, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2, 0);
        step(0, 1, 2, 1);
        check("fullpop_ovf", 32'(o_overflow), 32'h0);
        check("fullpop_level", 32'(o_level), 32'h4);

        // Gaps between pairs have no effect
        step(1, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            step(0, 1, (p % 2 == 0) ? 1 : 2, 0);
            if (p < 3) for (int g = 0; g < 3; g++) step(0, 0, 3, 0);
        end
        check("gap_level", 32'(o_level), 32'h1);
        check("gap_data", 32'(o_data), 32'h66);

        // Reset mid-byte discards partial byte
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0);
        step(1, 1, 3, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2, 0);
        check("rstmid_level", 32'(o_level), 32'h1);
        check("rstmid_data", 32'(o_data), 32'hAA);
`else
        // Extractor: 10,00,01,11 x4 -> 8'hAA
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 2, 0);
            step(0, 1, 0, 0);
            step(0, 1, 1, 0);
            step(0, 1, 3, 0);
        end
        check("vn_level", 32'(o_level), 32'h1);
        check("vn_data", 32'(o_data), 32'hAA);
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, (i % 2 == 0) ? 0 : 3, 0);
        check("vn_equal_pairs_valid", 32'(o_valid), 32'h0);
`endif

        // Randomized traffic
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rnd_byte_packer.md
# rnd_byte_packer

Downstream stage of the `randomizer` core. Consumes its 2-bit raw random output, packs samples into bytes and buffers them in a small show-ahead FIFO. Bytes are presented to the consumer (UART, SPI or host reader) through a valid/ready handshake. Loss of data when the FIFO is full is flagged by a sticky overflow bit.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: FIFO entries (bytes). Must be a power of 2 and ≥ 2.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_en`  in  1  sample qualifier; `i_r` is accepted on every cycle with `i_en`=1.
- `i_r`  in  2  raw random pair from `randomizer.o_r`.
- `i_ready`  in  1  consumer ready.
- `o_data`  out  8  FIFO head byte.
- `o_valid`  out  1  FIFO non-empty.
- `o_overflow`  out  1  sticky; set when a completed byte is dropped.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation

Packer:
- Raw mode shift register: `sh <= {sh[5:0], i_r}` on each accepted pair. Pair counter runs 0..3.
- The first accepted pair lands in `[7:6]` of the byte; the fourth lands in `[1:0]`.
- On the 4th accepted pair the completed byte `{sh[5:0], i_r}` is pushed. The counter then wraps to 0.
- `i_en`=0: shift register and counter hold. Gaps between pairs are allowed and have no effect on the byte.

FIFO:
- Show-ahead: `o_data` is the head entry while `o_valid`=1, and 8'h00 when empty.
- Pop occurs when `o_valid` && `i_ready`.
- Push while full:
  - If a pop happens in the same cycle, the push succeeds and `o_level` is unchanged.
  - Otherwise the byte is dropped and `o_overflow` is set to 1. FIFO contents are untouched.
- The pair/bit counter always wraps, whether or not the push succeeded.
- Pop on empty is ignored.
- Simultaneous push and pop when not full: `o_level` is unchanged.
- `o_overflow` is cleared only by `i_reset`.
- Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Full/empty are derived from `o_level`.

## Timing

- Reset values:
  - `o_valid`=0, `o_data`=8'h00, `o_overflow`=0, `o_level`=0.
  - Pair/bit counter = 0, shift register = 0, pointers = 0.
- Reset asserted mid-byte discards the partial byte. Reset also discards all FIFO contents.
- `i_en` and `i_r` are ignored during any cycle with `i_reset`=1.
- Push latency: the byte completed at edge N is visible on `o_data` with `o_valid`=1 after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Pop: the head advances at the edge where `o_valid` && `i_ready`. The next entry (or `o_valid`=0) appears in the following cycle.
- `o_level` and `o_overflow` update at the same edge as the push/pop that changes them.
- Throughput:
  - Raw mode: 1 byte per 4 accepted pairs.
  - The consumer may pop 1 byte per cycle.
- `i_ready` may be asserted independently of `o_valid`, and has no combinational path to any output.

## Configuration

`RND_PACKER_DEBIAS_EN`

Defined:
- Each accepted pair passes through a von Neumann extractor.
- `i_r`=2'b10 yields bit 1; 2'b01 yields bit 0; 2'b00 and 2'b11 are discarded and do not advance the counter.
- Yielded bits shift in MSB-first, `sh <= {sh[6:0], bit}`, with a bit counter running 0..7.
- A byte is pushed on the 8th yielded bit.
- All FIFO, handshake and overflow rules are unchanged.

Undefined:
- Raw packing of 4 pairs per byte, as described in Operation.
- No extractor logic is present.

## Test plan

- Reset, `i_ready`=1, `i_en`=1, pairs 11,00,10,01 → `o_valid`=1 with `o_data`=8'hC9 one cycle after the 4th pair; popped next edge; then `o_valid`=0 and `o_level`=0.
- `i_ready`=0, 16 pairs of 11 (FIFO_DEPTH=4) → `o_level`=4 and `o_overflow`=0. Then 4 more pairs of 11 → `o_overflow`=1 and `o_level` stays 4. Raise `i_ready` → exactly 4 bytes of 8'hFF drain.
- FIFO full and `i_ready`=1 in the same cycle the 4th pair arrives → no overflow and `o_level` stays 4.
- Pairs 01, 10, 01, 10 with `i_en` toggled low for 3 cycles between each pair → single byte 8'h66.
- 3 pairs accepted, `i_reset` pulsed 1 cycle, then 4 pairs of 10 → exactly one byte, 8'hAA, with no residue from before the reset.
- With `RND_PACKER_DEBIAS_EN`: the sequence 10,00,01,11 repeated 4× → one byte 8'hAA. 00 and 11 pairs alone never produce `o_valid`.
